// File: rtl/amplitude_envelope_scheduler.sv
// Sweeps NUM_CH channels through a shared OU envelope core on every sample tick,
// clamping each returned envelope and storing it with the advanced LFSR state.
module amplitude_envelope_scheduler #(
  parameter int WIDTH   = 18,
  parameter int FRAC    = 14,
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_ch,
  input  logic [15:0]             cfg_seed,
  input  logic signed [WIDTH-1:0] cfg_tau_inv,
  input  logic                    err_clr,
  output logic                    core_req,
  output logic [1:0]              core_ch,
  output logic signed [WIDTH-1:0] core_state,
  output logic [15:0]             core_seed,
  output logic signed [WIDTH-1:0] core_tau_inv,
  input  logic                    core_ack,
  input  logic signed [WIDTH-1:0] core_result,
  input  logic [15:0]             core_lfsr,
  output logic                    env_out_valid,
  output logic [1:0]              env_out_ch,
  output logic signed [WIDTH-1:0] env_out,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic signed [WIDTH-1:0] ENV_ONE = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0] ENV_LO  = WIDTH'(1 << (FRAC - 1));
  localparam logic signed [WIDTH-1:0] ENV_HI  = WIDTH'((1 << FRAC) + (1 << (FRAC - 1)));
  localparam logic [15:0]             SEED_DEF = 16'hACE1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              ch_q, ch_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    store;
  logic                    timeout_set;
  logic                    overrun_set;
  logic signed [WIDTH-1:0] clamped;
  logic [15:0]             lfsr_fixed;

  logic signed [WIDTH-1:0] env_q  [NUM_CH];
  logic [15:0]             seed_q [NUM_CH];
  logic signed [WIDTH-1:0] tau_q  [NUM_CH];

  logic                    valid_q;
  logic [1:0]              out_ch_q;
  logic signed [WIDTH-1:0] out_q;
  logic                    overrun_q;
  logic                    timeout_q;

  always_comb begin
    if (core_result < ENV_LO)      clamped = ENV_LO;
    else if (core_result > ENV_HI) clamped = ENV_HI;
    else                           clamped = core_result;
    lfsr_fixed = (core_lfsr == '0) ? SEED_DEF : core_lfsr;
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    wait_d      = wait_q;
    store       = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clk_en) begin
          ch_d    = '0;
          wait_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (core_ack) begin
          store   = 1'b1;
          state_d = S_WRITE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          // this unacknowledged cycle brings the wait count to TIMEOUT
          timeout_set = 1'b1;
          state_d     = S_WRITE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (ch_q == 2'(NUM_CH - 1)) begin
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + 2'd1;
          wait_d  = '0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign overrun_set = clk_en && (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      wait_q    <= '0;
      valid_q   <= 1'b0;
      out_ch_q  <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      wait_q  <= wait_d;
      valid_q <= store;
      if (store) begin
        out_ch_q <= ch_q;
        out_q    <= clamped;
      end
      if (overrun_set)  overrun_q <= 1'b1;
      else if (err_clr) overrun_q <= 1'b0;
      if (timeout_set)  timeout_q <= 1'b1;
      else if (err_clr) timeout_q <= 1'b0;
    end
  end

  // A configuration write to the channel being stored takes priority over the core result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        env_q[i]  <= ENV_ONE;
        seed_q[i] <= SEED_DEF + 16'(i);
        tau_q[i]  <= WIDTH'(1);
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cfg_we && 32'(cfg_ch) == i) begin
          env_q[i]  <= ENV_ONE;
          seed_q[i] <= (cfg_seed == '0) ? SEED_DEF : cfg_seed;
          tau_q[i]  <= cfg_tau_inv;
        end else if (store && 32'(ch_q) == i) begin
          env_q[i]  <= clamped;
          seed_q[i] <= lfsr_fixed;
        end
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign core_req      = (state_q == S_REQ);
  assign core_ch       = ch_q;
  assign core_state    = env_q[ch_q];
  assign core_seed     = seed_q[ch_q];
  // tau_inv is only driven during a request so the output bus rests at zero
  assign core_tau_inv  = core_req ? tau_q[ch_q] : '0;
  assign env_out_valid = valid_q;
  assign env_out_ch    = out_ch_q;
  assign env_out       = out_q;
  assign overrun       = overrun_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_amplitude_envelope_scheduler.sv
// Bench for amplitude_envelope_scheduler: a behavioural core responder plus a per-sweep
// timing/value model, exercised by directed scenarios and randomized sweeps.
module tb_amplitude_envelope_scheduler;

  localparam int WIDTH    = 18;
  localparam int NUM_CH   = 4;
  localparam int TIMEOUT  = 15;
  localparam int ENV_ONE  = 16384;
  localparam int SEED_DEF = 'hACE1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    clk_en;
  logic                    cfg_we;
  logic [1:0]              cfg_ch;
  logic [15:0]             cfg_seed;
  logic signed [WIDTH-1:0] cfg_tau_inv;
  logic                    err_clr;
  logic                    core_req;
  logic [1:0]              core_ch;
  logic signed [WIDTH-1:0] core_state;
  logic [15:0]             core_seed;
  logic signed [WIDTH-1:0] core_tau_inv;
  logic                    core_ack = 1'b0;
  logic signed [WIDTH-1:0] core_result = '0;
  logic [15:0]             core_lfsr = '0;
  logic                    env_out_valid;
  logic [1:0]              env_out_ch;
  logic signed [WIDTH-1:0] env_out;
  logic                    busy;
  logic                    overrun;
  logic                    timeout_err;

  amplitude_envelope_scheduler #(
    .WIDTH(WIDTH), .FRAC(14), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_seed(cfg_seed), .cfg_tau_inv(cfg_tau_inv),
    .err_clr(err_clr),
    .core_req(core_req), .core_ch(core_ch), .core_state(core_state),
    .core_seed(core_seed), .core_tau_inv(core_tau_inv),
    .core_ack(core_ack), .core_result(core_result), .core_lfsr(core_lfsr),
    .env_out_valid(env_out_valid), .env_out_ch(env_out_ch), .env_out(env_out),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model of the stored per-channel values.
  int env_m [NUM_CH];
  int seed_m[NUM_CH];
  int tau_m [NUM_CH];

  // Core behaviour per channel: ack after resp_delay non-ack cycles (-1 = never).
  int resp_delay [NUM_CH];
  int resp_result[NUM_CH];
  int resp_lfsr  [NUM_CH];

  int sv_t[$], sv_ch[$], sv_val[$];
  int rq_ch[$], rq_state[$], rq_seed[$], rq_tau[$], rq_len[$];
  int ex_t[$], ex_ch[$], ex_val[$];
  int exq_state[$], exq_seed[$], exq_tau[$], exq_len[$];
  int ex_idle;
  int unstable = 0;
  int req_cnt = 0;

  always @(negedge clk) begin
    if (env_out_valid) begin
      sv_t.push_back(cyc);
      sv_ch.push_back(int'(env_out_ch));
      sv_val.push_back(int'(env_out));
    end
    if (core_req) begin
      if (req_cnt == 0) begin
        rq_ch.push_back(int'(core_ch));
        rq_state.push_back(int'(core_state));
        rq_seed.push_back(int'(core_seed));
        rq_tau.push_back(int'(core_tau_inv));
      end else if (int'(core_ch) != rq_ch[$] || int'(core_state) != rq_state[$] ||
                   int'(core_seed) != rq_seed[$] || int'(core_tau_inv) != rq_tau[$]) begin
        unstable++;
      end
      if (resp_delay[core_ch] == req_cnt) begin
        core_ack    = 1'b1;
        core_result = WIDTH'(resp_result[core_ch]);
        core_lfsr   = 16'(resp_lfsr[core_ch]);
      end else begin
        core_ack = 1'b0;
      end
      req_cnt++;
    end else begin
      if (req_cnt != 0) rq_len.push_back(req_cnt);
      req_cnt  = 0;
      core_ack = 1'b0;
    end
  end

  function automatic int clampm(input int v);
    return (v < 8192) ? 8192 : ((v > 24576) ? 24576 : v);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      env_m[c]  = ENV_ONE;
      seed_m[c] = SEED_DEF + c;
      tau_m[c]  = 1;
    end
  endfunction

  // Expected strobes, request contents and idle cycle for a sweep whose tick is in cycle t.
  function automatic void predict(input int t);
    int  start;
    int  len;
    bit  acked;
    start = t + 1;
    ex_t.delete(); ex_ch.delete(); ex_val.delete();
    exq_state.delete(); exq_seed.delete(); exq_tau.delete(); exq_len.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      exq_state.push_back(env_m[c]);
      exq_seed.push_back(seed_m[c]);
      exq_tau.push_back(tau_m[c]);
      acked = (resp_delay[c] >= 0) && (resp_delay[c] < TIMEOUT);
      len   = acked ? resp_delay[c] + 1 : TIMEOUT;
      exq_len.push_back(len);
      if (acked) begin
        ex_t.push_back(start + len);
        ex_ch.push_back(c);
        ex_val.push_back(clampm(resp_result[c]));
        env_m[c]  = clampm(resp_result[c]);
        seed_m[c] = (resp_lfsr[c] == 0) ? SEED_DEF : resp_lfsr[c];
      end
      start = start + len + 1;
    end
    ex_idle = start;
  endfunction

  task automatic set_resp(input int d, input int r);
    for (int c = 0; c < NUM_CH; c++) begin
      resp_delay[c]  = d;
      resp_result[c] = r;
      resp_lfsr[c]   = 100 + c;
    end
  endtask

  task automatic start_sweep(output int t);
    sv_t.delete(); sv_ch.delete(); sv_val.delete();
    rq_ch.delete(); rq_state.delete(); rq_seed.delete(); rq_tau.delete(); rq_len.delete();
    @(negedge clk);
    clk_en = 1'b1;
    t = cyc;
    predict(t);
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic finish_sweep(output int idle_cyc);
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    idle_cyc = cyc;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_done: busy=%b, required 0 within 400 cycles", busy);
    end
  endtask

  task automatic cfg_write(input int ch, input int seed, input int tau);
    cfg_we      = 1'b1;
    cfg_ch      = 2'(ch);
    cfg_seed    = 16'(seed);
    cfg_tau_inv = WIDTH'(tau);
    @(negedge clk);
    cfg_we = 1'b0;
    env_m[ch]  = ENV_ONE;
    seed_m[ch] = (seed == 0) ? SEED_DEF : seed;
    tau_m[ch]  = tau;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_seed = '0;
    cfg_tau_inv = '0; err_clr = 1'b0;
    set_resp(0, 20000);
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, core_req, env_out_valid, overrun, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: busy/req/valid/ovr/tmo=%b, required 00000",
               {busy, core_req, env_out_valid, overrun, timeout_err});
    end
    checks++;
    if (core_state !== WIDTH'(ENV_ONE) || core_seed !== 16'hACE1) begin
      errors++;
      $display("FAIL reset_core: state=%0d seed=%h, required 16384 ace1", core_state, core_seed);
    end
    checks++;
    if (core_tau_inv !== '0 || core_ch !== 2'd0 || env_out !== '0 || env_out_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_zero: tau=%0d ch=%0d env=%0d och=%0d, required 0",
               core_tau_inv, core_ch, env_out, env_out_ch);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic_sweep();
    int t, idle;
    set_resp(0, 20000);
    start_sweep(t);
    finish_sweep(idle);
    checks++;
    if (sv_t.size() != 4) begin
      errors++;
      $display("FAIL basic_count: strobes=%0d, required 4", sv_t.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= sv_t.size() || sv_t[i] != t + 2 + 2 * i || sv_ch[i] != i || sv_val[i] != 20000) begin
        errors++;
        $display("FAIL basic_strobe%0d: got %0d strobes, required cycle=%0d ch=%0d env=20000",
                 i, sv_t.size(), t + 2 + 2 * i, i);
      end
      checks++;
      if (i >= rq_ch.size() || rq_state[i] != ENV_ONE || rq_seed[i] != SEED_DEF + i || rq_tau[i] != 1) begin
        errors++;
        $display("FAIL basic_req%0d: got %0d requests, required state=16384 seed=%h tau=1",
                 i, rq_ch.size(), SEED_DEF + i);
      end
    end
    checks++;
    if (idle != t + 9) begin
      errors++;
      $display("FAIL basic_idle: idle at t+%0d, required t+9", idle - t);
    end
  endtask

  task automatic test_clamp();
    int t, idle;
    set_resp(0, 30000);
    start_sweep(t);
    finish_sweep(idle);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= sv_val.size() || sv_val[i] != 24576) begin
        errors++;
        $display("FAIL clamp_hi%0d: strobes=%0d, required env=24576", i, sv_val.size());
      end
    end
    set_resp(0, -5);
    start_sweep(t);
    finish_sweep(idle);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= sv_val.size() || i >= rq_state.size() || sv_val[i] != 8192 || rq_state[i] != 24576) begin
        errors++;
        $display("FAIL clamp_lo%0d: strobes=%0d reqs=%0d, required env=8192 fed-back=24576",
                 i, sv_val.size(), rq_state.size());
      end
    end
    set_resp(0, 20000);
    start_sweep(t);
    finish_sweep(idle);
    checks++;
    if (rq_state.size() != 4 || rq_state[0] != 8192 || rq_state[3] != 8192) begin
      errors++;
      $display("FAIL clamp_feedback: reqs=%0d, required core_state=8192", rq_state.size());
    end
  endtask

  task automatic test_timeout();
    int t, idle;
    apply_reset();
    set_resp(0, 20000);
    resp_delay[1] = -1;
    start_sweep(t);
    finish_sweep(idle);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: timeout_err=%b, required 1", timeout_err);
    end
    checks++;
    if (sv_ch.size() != 3 || sv_ch[0] != 0 || sv_ch[1] != 2 || sv_ch[2] != 3) begin
      errors++;
      $display("FAIL timeout_strobes: count=%0d, required channels 0,2,3", sv_ch.size());
    end
    checks++;
    if (sv_t.size() != 3 || sv_t[1] != t + 20 || sv_t[2] != t + 22 || idle != t + 23) begin
      errors++;
      $display("FAIL timeout_timing: idle t+%0d, required ch2 t+20 ch3 t+22 idle t+23", idle - t);
    end
    checks++;
    if (rq_len.size() != 4 || rq_len[1] != TIMEOUT || rq_ch[2] != 2) begin
      errors++;
      $display("FAIL timeout_wait: reqs=%0d, required ch1 15 cycles then ch2", rq_len.size());
    end
    set_resp(0, 20000);
    start_sweep(t);
    finish_sweep(idle);
    checks++;
    if (rq_state.size() != 4 || rq_state[1] != ENV_ONE || rq_seed[1] != SEED_DEF + 1) begin
      errors++;
      $display("FAIL timeout_kept: reqs=%0d, required ch1 state 16384 seed ace2", rq_state.size());
    end
    pulse_err_clr();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: timeout_err=%b, required 0", timeout_err);
    end
  endtask

  task automatic test_overrun();
    int t, idle;
    set_resp(0, 15000);
    start_sweep(t);
    repeat (3) @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    finish_sweep(idle);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: overrun=%b, required 1", overrun);
    end
    checks++;
    if (sv_t.size() != 4 || idle != t + 9) begin
      errors++;
      $display("FAIL overrun_strobes: count=%0d idle t+%0d, required 4 and t+9", sv_t.size(), idle - t);
    end
    repeat (5) @(negedge clk);
    pulse_err_clr();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
    end
    start_sweep(t);
    clk_en  = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    clk_en  = 1'b0;
    err_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: overrun=%b, required 1", overrun);
    end
    finish_sweep(idle);
    pulse_err_clr();
  endtask

  task automatic test_cfg();
    int t, idle;
    cfg_write(2, 0, 3);
    cfg_write(3, 'hBEEF, -7);
    set_resp(0, 12000);
    resp_lfsr[0] = 0;
    start_sweep(t);
    finish_sweep(idle);
    checks++;
    if (rq_state.size() != 4 || rq_seed[2] != SEED_DEF || rq_tau[2] != 3 || rq_state[2] != ENV_ONE) begin
      errors++;
      $display("FAIL cfg_ch2: reqs=%0d, required seed ace1 tau 3 state 16384", rq_state.size());
    end
    checks++;
    if (rq_state.size() != 4 || rq_seed[3] != 'hBEEF || rq_tau[3] != -7 || rq_state[3] != ENV_ONE) begin
      errors++;
      $display("FAIL cfg_ch3: reqs=%0d, required seed beef tau -7 state 16384", rq_state.size());
    end
    start_sweep(t);
    finish_sweep(idle);
    checks++;
    if (rq_seed.size() != 4 || rq_seed[0] != SEED_DEF || rq_state[2] != 12000) begin
      errors++;
      $display("FAIL lfsr_zero: reqs=%0d, required ch0 seed ace1 ch2 state 12000", rq_seed.size());
    end
  endtask

  task automatic test_cfg_collision();
    int t, idle;
    set_resp(0, 0);
    resp_delay[2]  = 3;
    resp_result[0] = 10000; resp_result[1] = 15000; resp_result[2] = 21000; resp_result[3] = 9000;
    start_sweep(t);
    for (int i = 0; i < 60 && !(core_req && core_ch == 2'd1); i++) @(negedge clk);
    checks++;
    if (!(core_req && core_ch == 2'd1)) begin
      errors++;
      $display("FAIL collide_wait1: core_req=%b ch=%0d, required ch1 request", core_req, core_ch);
    end
    cfg_write(1, 'h1234, 7);
    for (int i = 0; i < 60 && !(core_req && core_ch == 2'd2); i++) @(negedge clk);
    cfg_write(2, 'h5555, 9);
    checks++;
    if (core_req !== 1'b1 || core_ch !== 2'd2 || core_seed !== 16'h5555 ||
        core_tau_inv !== WIDTH'(9) || core_state !== WIDTH'(ENV_ONE)) begin
      errors++;
      $display("FAIL collide_live: req=%b ch=%0d seed=%h tau=%0d state=%0d, required 1 2 5555 9 16384",
               core_req, core_ch, core_seed, core_tau_inv, core_state);
    end
    // ch2's ack follows the cfg write, so the core result is what ends up stored
    env_m[2]  = clampm(resp_result[2]);
    seed_m[2] = resp_lfsr[2];
    finish_sweep(idle);
    checks++;
    if (sv_val.size() != 4 || sv_val[1] != 15000 || sv_val[2] != 21000) begin
      errors++;
      $display("FAIL collide_strobes: count=%0d, required 4 with ch1 15000 ch2 21000", sv_val.size());
    end
    set_resp(0, 20000);
    start_sweep(t);
    finish_sweep(idle);
    checks++;
    if (rq_state.size() != 4 || rq_state[1] != ENV_ONE || rq_seed[1] != 'h1234 || rq_tau[1] != 7) begin
      errors++;
      $display("FAIL collide_cfg_wins: reqs=%0d, required ch1 state 16384 seed 1234 tau 7", rq_state.size());
    end
    checks++;
    if (rq_state.size() != 4 || rq_state[2] != 21000 || rq_seed[2] != 102 || rq_tau[2] != 9) begin
      errors++;
      $display("FAIL collide_ch2: reqs=%0d, required ch2 state 21000 seed 102 tau 9", rq_state.size());
    end
  endtask

  task automatic test_reset_mid();
    int t, idle;
    set_resp(0, 20000);
    start_sweep(t);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, core_req, env_out_valid} !== 3'b0 || core_state !== WIDTH'(ENV_ONE) || core_seed !== 16'hACE1) begin
      errors++;
      $display("FAIL reset_async: busy/req/valid=%b state=%0d seed=%h, required 000 16384 ace1",
               {busy, core_req, env_out_valid}, core_state, core_seed);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (20) @(negedge clk);
    checks++;
    if (sv_t.size() != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: strobes=%0d busy=%b, required 2 and 0", sv_t.size(), busy);
    end
    start_sweep(t);
    finish_sweep(idle);
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (c >= rq_state.size() || rq_state[c] != ENV_ONE || rq_seed[c] != SEED_DEF + c || rq_tau[c] != 1) begin
        errors++;
        $display("FAIL reset_values%0d: reqs=%0d, required state 16384 seed %h tau 1",
                 c, rq_state.size(), SEED_DEF + c);
      end
    end
  endtask

  task automatic test_random();
    int t, idle;
    unstable = 0;
    for (int s = 0; s < 8; s++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 65535)),
                  int'($urandom_range(0, 2000)) - 1000);
      for (int c = 0; c < NUM_CH; c++) begin
        resp_delay[c]  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
        resp_result[c] = int'($urandom_range(0, 100000)) - 50000;
        resp_lfsr[c]   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 65535));
      end
      start_sweep(t);
      finish_sweep(idle);
      checks++;
      if (sv_t.size() != ex_t.size() || idle != ex_idle) begin
        errors++;
        $display("FAIL rand%0d_count: strobes=%0d idle t+%0d, required %0d and t+%0d",
                 s, sv_t.size(), idle - t, ex_t.size(), ex_idle - t);
      end
      for (int i = 0; i < ex_t.size(); i++) begin
        checks++;
        if (i >= sv_t.size() || sv_t[i] != ex_t[i] || sv_ch[i] != ex_ch[i] || sv_val[i] != ex_val[i]) begin
          errors++;
          $display("FAIL rand%0d_strobe%0d: strobes=%0d, required cycle t+%0d ch %0d env %0d",
                   s, i, sv_t.size(), ex_t[i] - t, ex_ch[i], ex_val[i]);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        checks++;
        if (c >= rq_ch.size() || c >= rq_len.size() || rq_ch[c] != c || rq_state[c] != exq_state[c] ||
            rq_seed[c] != exq_seed[c] || rq_tau[c] != exq_tau[c] || rq_len[c] != exq_len[c]) begin
          errors++;
          $display("FAIL rand%0d_req%0d: reqs=%0d, required state %0d seed %h tau %0d len %0d",
                   s, c, rq_ch.size(), exq_state[c], exq_seed[c], exq_tau[c], exq_len[c]);
        end
      end
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL req_stable: changes during request=%0d, required 0", unstable);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_clamp();
    test_timeout();
    test_overrun();
    test_cfg();
    test_cfg_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/amplitude_envelope_scheduler.md
AMPLITUDE_ENVELOPE_SCHEDULER -- requirements
Module: amplitude_envelope_scheduler

Interface
REQ-001 Parameters SHALL be: WIDTH, 18, sample width; FRAC, 14, fraction bits; NUM_CH, 4, channel count; TIMEOUT, 15, max wait cycles for core_ack.
REQ-002 Ports SHALL be, in order:
- clk, in, 1, system clock (125 MHz).
- rst_n, in, 1, asynchronous active-low reset.
- clk_en, in, 1, sample tick; one cycle wide.
- cfg_we, in, 1, configuration write strobe.
- cfg_ch, in, 2, channel to configure.
- cfg_seed, in, 16, channel LFSR seed.
- cfg_tau_inv, in, WIDTH signed, channel inverse time constant.
- err_clr, in, 1, clears sticky error flags.
- core_req, out, 1, update request to the shared OU envelope core.
- core_ch, out, 2, channel being updated.
- core_state, out, WIDTH signed, stored envelope for core_ch.
- core_seed, out, 16, stored LFSR for core_ch.
- core_tau_inv, out, WIDTH signed, tau_inv for core_ch.
- core_ack, in, 1, core result valid.
- core_result, in, WIDTH signed, new envelope.
- core_lfsr, in, 16, advanced LFSR state.
- env_out_valid, out, 1, one-cycle strobe per updated channel.
- env_out_ch, out, 2, channel of env_out.
- env_out, out, WIDTH signed, clamped envelope.
- busy, out, 1, high whenever the FSM is not IDLE.
- overrun, out, 1, sticky: clk_en arrived while busy.
- timeout_err, out, 1, sticky: core_ack missing for a channel.

Function
REQ-003 FSM SHALL have states IDLE, REQ and WRITE, with busy = (state != IDLE).
REQ-004 IDLE with clk_en=1 SHALL load ch=0 and enter REQ on the next cycle. Otherwise the FSM stays in IDLE.
REQ-005 In REQ, core_req SHALL be 1 and core_ch/state/seed/tau_inv SHALL present channel ch's stored values. These outputs SHALL be stable until ack or timeout.
REQ-006 REQ with core_ack=1 SHALL sample core_result and core_lfsr in that cycle and enter WRITE. Zero-wait ack in the first REQ cycle is legal.
REQ-007 Wait counter:
- Cleared on REQ entry; increments each REQ cycle without ack.
- When it equals TIMEOUT without ack: set timeout_err and enter WRITE with the update suppressed.
- Suppressed update: stored state and LFSR unchanged, env_out_valid held 0.
REQ-008 Entering WRITE with a normal update SHALL clamp core_result to [8192, 24576] and store it with core_lfsr into channel ch. In WRITE, env_out_valid SHALL be 1 with env_out_ch=ch and env_out=the clamped value.
REQ-009 Leaving WRITE: if ch = NUM_CH-1, go to IDLE; else increment ch and go to REQ.
REQ-010 Timing with zero-wait ack, clk_en at cycle t:
- REQ ch0 at t+1, WRITE ch0 at t+2.
- WRITE ch3 at t+8, IDLE at t+9.
- Minimum tick period: 9 cycles.
REQ-011 clk_en seen while busy SHALL set overrun and SHALL NOT be queued or restart the sweep.
REQ-012 cfg_we=1 SHALL, on the next edge, write the channel's tau_inv, seed and envelope:
- tau_inv = cfg_tau_inv.
- seed = cfg_seed, replaced by 16'hACE1 if cfg_seed is 0.
- envelope = 16384.
REQ-013 If cfg_we targets the channel being stored in the same cycle, the cfg write SHALL win. If it targets the channel in REQ, it SHALL take effect immediately (core_* follow it).
REQ-014 err_clr SHALL clear overrun and timeout_err. If a set and a clear occur in the same cycle, the set SHALL win.
REQ-015 core_lfsr = 0 SHALL be stored as 16'hACE1.

Reset
REQ-016 rst_n=0 SHALL asynchronously force the following, independent of clk:
- FSM to IDLE, ch=0.
- Every envelope = 16384, seed = 16'hACE1 + channel index, tau_inv = 1.
- All outputs 0, except core_state = 16384 and core_seed = 16'hACE1.
REQ-017 Reset asserted mid-sweep SHALL abandon the sweep. No env_out_valid SHALL follow until a new clk_en.

Verification
REQ-018 Zero-wait ack returning result 20000, single clk_en -> four env_out_valid strobes at t+2, t+4, t+6, t+8 for ch 0..3, each with env_out=20000; busy low at t+9.
REQ-019 core_result 30000, then -5 -> env_out 24576, then 8192; the stored state fed back on core_state equals the clamped value.
REQ-020 core_ack withheld for ch1 -> timeout_err=1 after 15 REQ cycles; no strobe for ch1; ch1 state stays 16384; ch2 is then requested.
REQ-021 clk_en at t and t+4 -> overrun=1, only 4 strobes; err_clr then clears overrun.
REQ-022 cfg_we ch2, seed 0, tau 3 -> during the next sweep core_seed=16'hACE1, core_tau_inv=3 and core_state=16384 for ch2.
REQ-023 rst_n pulsed low at t+5 -> immediately idle, all stored envelopes 16384, no further strobes.
